conv_punct_enc: RTL and testbench

//  Parametrised convolutional encoder (rate 1/2 mother code, constraint length K) with runtime

---
 rtl/conv_punct_enc.sv | 173 +++++++++++++++++
 tb/tb_conv_punct_enc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_punct_enc.sv
// Rate-1/2 convolutional encoder with runtime puncturing to 2/3 or 3/4, per-frame length
// control, optional zero-tail flush and a registered serial output stream.
module conv_punct_enc #(
  parameter int unsigned    K       = 7,
  parameter logic [K-1:0]   G0      = 7'o171,
  parameter logic [K-1:0]   G1      = 7'o133,
  parameter int unsigned    LEN_W   = 12,
  parameter int unsigned    TAIL_EN = 1
) (
  input  logic             conv_clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [1:0]       rate_sel,
  input  logic             in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned TW = $clog2(K);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [K-2:0]     sr;
  logic [1:0]       obuf;
  logic [1:0]       cnt;
  logic [1:0]       phase;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       rate_q;
  logic [TW-1:0]    tail_cnt;

  logic             start_ok;
  logic             space_ok;
  logic             accept;
  logic             inject;
  logic             push;
  logic             enc_bit;
  logic [K-1:0]     word;
  logic             code_a;
  logic             code_b;
  logic             keep_a;
  logic             keep_b;
  logic             last_phase;
  logic             last_data;
  logic             last_tail;

  assign start_ok = frame_start && (frame_len != '0);
  assign space_ok = (cnt <= 2'd1);
  assign accept   = (state == RUN) && in_valid && space_ok;
  assign inject   = (state == TAIL) && space_ok;
  assign push     = accept || inject;
  assign enc_bit  = (state == RUN) ? in_data : 1'b0;
  assign word     = {enc_bit, sr};
  assign code_a   = ^(G0 & word);
  assign code_b   = ^(G1 & word);

  assign in_ready  = (state == RUN) && space_ok;
  assign busy      = (state != IDLE);
  assign last_data = ((bit_cnt + LEN_W'(1)) == len_q);
  assign last_tail = (tail_cnt == TW'(K - 2));

  // Puncture pattern per latched rate; code 11 falls back to the unpunctured mother code.
  always_comb begin
    keep_a     = 1'b1;
    keep_b     = 1'b1;
    last_phase = 1'b1;
    case (rate_q)
      2'b01: begin
        keep_b     = (phase == 2'd0);
        last_phase = (phase == 2'd1);
      end
      2'b10: begin
        keep_b     = (phase != 2'd1);
        keep_a     = (phase != 2'd2);
        last_phase = (phase == 2'd2);
      end
      default: begin
        keep_a     = 1'b1;
        keep_b     = 1'b1;
        last_phase = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (accept && last_data) state_nx = (TAIL_EN != 0) ? TAIL : DRAIN;
      TAIL:    if (inject && last_tail) state_nx = DRAIN;
      DRAIN:   if (cnt <= 2'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge conv_clk) begin
    if (!reset) begin
      state     <= IDLE;
      sr        <= '0;
      obuf      <= '0;
      cnt       <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      len_q     <= '0;
      rate_q    <= '0;
      tail_cnt  <= '0;
      out_data  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nx;

      if ((state == IDLE) && start_ok) begin
        sr       <= '0;
        phase    <= '0;
        bit_cnt  <= '0;
        tail_cnt <= '0;
        len_q    <= frame_len;
        rate_q   <= rate_sel;
      end

      if (push) begin
        sr    <= {enc_bit, sr[K-2:1]};
        phase <= last_phase ? 2'd0 : phase + 2'd1;
      end
      if (accept) bit_cnt  <= bit_cnt + LEN_W'(1);
      if (inject) tail_cnt <= tail_cnt + TW'(1);

      out_valid <= (cnt != 2'd0);
      out_last  <= (state == DRAIN) && (cnt == 2'd1);
      if (cnt != 2'd0) out_data <= obuf[0];

      // A push only happens with cnt<=1, so after this cycle's pop the buffer is empty
      // and the freshly kept bits can simply overwrite it (B at the head, then A).
      if (push) begin
        case ({keep_b, keep_a})
          2'b11: begin
            obuf <= {code_a, code_b};
            cnt  <= 2'd2;
          end
          2'b10: begin
            obuf <= {1'b0, code_b};
            cnt  <= 2'd1;
          end
          2'b01: begin
            obuf <= {1'b0, code_a};
            cnt  <= 2'd1;
          end
          default: begin
            obuf <= '0;
            cnt  <= 2'd0;
          end
        endcase
      end else if (cnt != 2'd0) begin
        obuf <= {1'b0, obuf[1]};
        cnt  <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_punct_enc.sv
// Randomised and directed bench for conv_punct_enc: three instances (K=3 tail, K=7 tail,
// K=5 no tail) checked against a queue-based encode/puncture reference model.
module tb_conv_punct_enc;

  logic conv_clk = 1'b0;
  always #5 conv_clk = ~conv_clk;

  logic       reset;
  logic [2:0] fs_v;
  logic [2:0] d_v;
  logic [2:0] v_v;
  logic [11:0] len_a [3];
  logic [1:0]  rate_a [3];
  wire  [2:0] rdy_v;
  wire  [2:0] od_v;
  wire  [2:0] ov_v;
  wire  [2:0] ol_v;
  wire  [2:0] busy_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit oq [3][$];
  int nlast [3];
  int lastpos [3];
  int first_cyc [3];
  int last_cyc [3];

  conv_punct_enc #(.K(3), .G0(3'b111), .G1(3'b101), .LEN_W(12), .TAIL_EN(1)) u_k3 (
    .conv_clk(conv_clk), .reset(reset), .frame_start(fs_v[0]), .frame_len(len_a[0]),
    .rate_sel(rate_a[0]), .in_data(d_v[0]), .in_valid(v_v[0]), .in_ready(rdy_v[0]),
    .out_data(od_v[0]), .out_valid(ov_v[0]), .out_last(ol_v[0]), .busy(busy_v[0]));

  conv_punct_enc #(.K(7), .G0(7'o171), .G1(7'o133), .LEN_W(12), .TAIL_EN(1)) u_k7 (
    .conv_clk(conv_clk), .reset(reset), .frame_start(fs_v[1]), .frame_len(len_a[1]),
    .rate_sel(rate_a[1]), .in_data(d_v[1]), .in_valid(v_v[1]), .in_ready(rdy_v[1]),
    .out_data(od_v[1]), .out_valid(ov_v[1]), .out_last(ol_v[1]), .busy(busy_v[1]));

  conv_punct_enc #(.K(5), .G0(5'o23), .G1(5'o35), .LEN_W(12), .TAIL_EN(0)) u_k5 (
    .conv_clk(conv_clk), .reset(reset), .frame_start(fs_v[2]), .frame_len(len_a[2]),
    .rate_sel(rate_a[2]), .in_data(d_v[2]), .in_valid(v_v[2]), .in_ready(rdy_v[2]),
    .out_data(od_v[2]), .out_valid(ov_v[2]), .out_last(ol_v[2]), .busy(busy_v[2]));

  always @(posedge conv_clk) cyc++;

  always @(negedge conv_clk) begin
    for (int s = 0; s < 3; s++) begin
      if (reset === 1'b1 && ov_v[s] === 1'b1) begin
        oq[s].push_back(od_v[s]);
        if (first_cyc[s] < 0) first_cyc[s] = cyc;
        last_cyc[s] = cyc;
        if (ol_v[s] === 1'b1) begin
          nlast[s]++;
          lastpos[s] = oq[s].size() - 1;
        end
      end
    end
  end

  // Reference: zero-prefixed bit history, tap-by-tap parity, then a keep table per phase.
  function automatic void model(input int s, input bit din[$], input int rate, output bit q[$]);
    int k; int g0; int g1; bit tail; int period; int p; int pa; int pb;
    bit x[$];
    case (s)
      0:       begin k = 3; g0 = 'b111;  g1 = 'b101;  tail = 1; end
      1:       begin k = 7; g0 = 'o171;  g1 = 'o133;  tail = 1; end
      default: begin k = 5; g0 = 'o23;   g1 = 'o35;   tail = 0; end
    endcase
    for (int i = 0; i < k - 1; i++) x.push_back(1'b0);
    foreach (din[i]) x.push_back(din[i]);
    if (tail) for (int i = 0; i < k - 1; i++) x.push_back(1'b0);
    period = (rate == 1) ? 2 : (rate == 2) ? 3 : 1;
    q.delete();
    for (int i = k - 1; i < x.size(); i++) begin
      pa = 0; pb = 0;
      for (int j = 0; j < k; j++) begin
        pa += ((g0 >> (k - 1 - j)) & 1) * int'(x[i - j]);
        pb += ((g1 >> (k - 1 - j)) & 1) * int'(x[i - j]);
      end
      p = (i - (k - 1)) % period;
      if (!(period > 1 && p == 1)) q.push_back(bit'(pb % 2));
      if (!(period == 3 && p == 2)) q.push_back(bit'(pa % 2));
    end
  endfunction

  task automatic clear_mon(input int s);
    oq[s].delete();
    nlast[s] = 0;
    lastpos[s] = -1;
    first_cyc[s] = -1;
    last_cyc[s] = -1;
  endtask

  task automatic start_frame(input int s, input int len, input int rate);
    @(posedge conv_clk); #1;
    fs_v[s] = 1'b1;
    len_a[s] = 12'(len);
    rate_a[s] = 2'(rate);
    @(posedge conv_clk); #1;
    fs_v[s] = 1'b0;
  endtask

  task automatic feed(input int s, input bit din[$], input int gap_at, input int gap_len,
                      output int ncyc, output bit gap_ov);
    int w;
    ncyc = 0;
    gap_ov = 1'b0;
    for (int i = 0; i < din.size(); i++) begin
      w = 0;
      d_v[s] = din[i];
      v_v[s] = 1'b1;
      @(negedge conv_clk);
      while (rdy_v[s] !== 1'b1 && w < 20) begin
        @(posedge conv_clk); #1; ncyc++; w++;
        @(negedge conv_clk);
      end
      if (w >= 20) begin
        errors++; checks++;
        $display("FAIL feed_timeout inst=%0d bit=%0d in_ready=%b required 1", s, i, rdy_v[s]);
        v_v[s] = 1'b0;
        return;
      end
      @(posedge conv_clk); #1; ncyc++;
      if (i == gap_at) begin
        v_v[s] = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge conv_clk);
          if (g >= 3 && ov_v[s] === 1'b1) gap_ov = 1'b1;
          @(posedge conv_clk); #1;
        end
      end
    end
    v_v[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge conv_clk); #1;
      if (nlast[s] > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge conv_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge conv_clk);
    @(negedge conv_clk);
    for (int s = 0; s < 3; s++) begin
      checks++; if (busy_v[s] !== 1'b0) begin errors++; $display("FAIL reset_busy inst=%0d got=%b exp=0", s, busy_v[s]); end
      checks++; if (rdy_v[s] !== 1'b0) begin errors++; $display("FAIL reset_in_ready inst=%0d got=%b exp=0", s, rdy_v[s]); end
      checks++; if (ov_v[s] !== 1'b0) begin errors++; $display("FAIL reset_out_valid inst=%0d got=%b exp=0", s, ov_v[s]); end
      checks++; if (od_v[s] !== 1'b0) begin errors++; $display("FAIL reset_out_data inst=%0d got=%b exp=0", s, od_v[s]); end
      checks++; if (ol_v[s] !== 1'b0) begin errors++; $display("FAIL reset_out_last inst=%0d got=%b exp=0", s, ol_v[s]); end
    end
    @(posedge conv_clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_t1_rate12;
    bit din[$] = '{1, 0, 1, 1};
    bit vec[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
    int ncyc; bit gov; bit ok;
    clear_mon(0);
    start_frame(0, 4, 0);
    feed(0, din, -1, 0, ncyc, gov);
    wait_done(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_done got=no_out_last exp=out_last"); end
    checks++; if (oq[0].size() != 12) begin errors++; $display("FAIL t1_len got=%0d exp=12", oq[0].size()); end
    for (int i = 0; i < 12 && i < oq[0].size(); i++) begin
      checks++; if (oq[0][i] !== vec[i]) begin errors++; $display("FAIL t1_bit%0d got=%b exp=%b", i, oq[0][i], vec[i]); end
    end
    checks++; if (lastpos[0] != 11 || nlast[0] != 1) begin errors++; $display("FAIL t1_last got_pos=%0d n=%0d exp_pos=11 n=1", lastpos[0], nlast[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL t1_busy_after got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_t2_rate34;
    bit din[$] = '{1, 0, 1, 1};
    bit vec[8] = '{1, 1, 1, 0, 1, 0, 0, 1};
    int ncyc; bit gov; bit ok;
    clear_mon(0);
    start_frame(0, 4, 2);
    feed(0, din, -1, 0, ncyc, gov);
    wait_done(0, ok);
    checks++; if (oq[0].size() != 8) begin errors++; $display("FAIL t2_len got=%0d exp=8", oq[0].size()); end
    for (int i = 0; i < 8 && i < oq[0].size(); i++) begin
      checks++; if (oq[0][i] !== vec[i]) begin errors++; $display("FAIL t2_bit%0d got=%b exp=%b", i, oq[0][i], vec[i]); end
    end
    checks++; if (lastpos[0] != 7 || nlast[0] != 1) begin errors++; $display("FAIL t2_last got_pos=%0d n=%0d exp_pos=7 n=1", lastpos[0], nlast[0]); end
  endtask

  task automatic test_t3_sustained;
    bit din[$]; bit exp[$];
    int ncyc; bit gov; bit ok; int bad;
    for (int i = 0; i < 48; i++) din.push_back(bit'($urandom_range(0, 1)));
    model(1, din, 0, exp);
    clear_mon(1);
    start_frame(1, 48, 0);
    feed(1, din, -1, 0, ncyc, gov);
    wait_done(1, ok);
    checks++; if (ncyc != 95) begin errors++; $display("FAIL t3_accept_cycles got=%0d exp=95", ncyc); end
    checks++; if (oq[1].size() != 108) begin errors++; $display("FAIL t3_len got=%0d exp=108", oq[1].size()); end
    checks++; if (last_cyc[1] - first_cyc[1] + 1 != oq[1].size()) begin
      errors++; $display("FAIL t3_continuous got_span=%0d exp=%0d", last_cyc[1] - first_cyc[1] + 1, oq[1].size());
    end
    bad = 0;
    for (int i = 0; i < exp.size() && i < oq[1].size(); i++) if (oq[1][i] !== exp[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t3_bits got_mismatches=%0d exp=0", bad); end
    checks++; if (lastpos[1] != 107) begin errors++; $display("FAIL t3_last got=%0d exp=107", lastpos[1]); end
  endtask

  task automatic test_t4_gap;
    bit din[$]; bit exp[$];
    int ncyc; bit gov; bit ok; int bad;
    for (int i = 0; i < 3; i++) din.push_back(bit'($urandom_range(0, 1)));
    model(1, din, 1, exp);
    clear_mon(1);
    start_frame(1, 3, 1);
    feed(1, din, 1, 5, ncyc, gov);
    wait_done(1, ok);
    checks++; if (gov !== 1'b0) begin errors++; $display("FAIL t4_gap_out_valid got=1 exp=0"); end
    checks++; if (oq[1].size() != exp.size()) begin errors++; $display("FAIL t4_len got=%0d exp=%0d", oq[1].size(), exp.size()); end
    bad = 0;
    for (int i = 0; i < exp.size() && i < oq[1].size(); i++) if (oq[1][i] !== exp[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL t4_bits got_mismatches=%0d exp=0", bad); end
    checks++; if (lastpos[1] != exp.size() - 1) begin errors++; $display("FAIL t4_last got=%0d exp=%0d", lastpos[1], exp.size() - 1); end
  endtask

  task automatic test_t5_ignored_starts;
    bit din[$] = '{1, 0, 1, 1};
    bit vec[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
    int ncyc; bit gov; bit ok;
    clear_mon(0);
    start_frame(0, 0, 0);
    @(negedge conv_clk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL t5_len0_busy got=%b exp=0", busy_v[0]); end
    checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL t5_len0_in_ready got=%b exp=0", rdy_v[0]); end
    repeat (3) @(posedge conv_clk);
    @(negedge conv_clk);
    checks++; if (ov_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      errors++; $display("FAIL t5_len0_idle got_valid=%b busy=%b exp=0,0", ov_v[0], busy_v[0]);
    end
    start_frame(0, 4, 0);
    fork
      feed(0, din, -1, 0, ncyc, gov);
      begin
        repeat (3) @(posedge conv_clk);
        #1; fs_v[0] = 1'b1; len_a[0] = 12'd2; rate_a[0] = 2'd2;
        @(posedge conv_clk); #1; fs_v[0] = 1'b0;
      end
    join
    wait_done(0, ok);
    checks++; if (oq[0].size() != 12) begin errors++; $display("FAIL t5_len got=%0d exp=12", oq[0].size()); end
    for (int i = 0; i < 12 && i < oq[0].size(); i++) begin
      checks++; if (oq[0][i] !== vec[i]) begin errors++; $display("FAIL t5_bit%0d got=%b exp=%b", i, oq[0][i], vec[i]); end
    end
  endtask

  task automatic test_t6_reset_midframe;
    bit din2[$] = '{1, 0};
    bit din[$] = '{1, 0, 1, 1};
    bit vec[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
    int ncyc; bit gov; bit ok;
    start_frame(0, 4, 0);
    feed(0, din2, -1, 0, ncyc, gov);
    @(negedge conv_clk);
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL t6_busy_before got=%b exp=1", busy_v[0]); end
    @(posedge conv_clk); #1; reset = 1'b0;
    @(posedge conv_clk); #1; reset = 1'b1;
    @(negedge conv_clk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL t6_busy got=%b exp=0", busy_v[0]); end
    checks++; if (ov_v[0] !== 1'b0) begin errors++; $display("FAIL t6_out_valid got=%b exp=0", ov_v[0]); end
    checks++; if (od_v[0] !== 1'b0) begin errors++; $display("FAIL t6_out_data got=%b exp=0", od_v[0]); end
    checks++; if (ol_v[0] !== 1'b0) begin errors++; $display("FAIL t6_out_last got=%b exp=0", ol_v[0]); end
    checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL t6_in_ready got=%b exp=0", rdy_v[0]); end
    clear_mon(0);
    start_frame(0, 4, 0);
    feed(0, din, -1, 0, ncyc, gov);
    wait_done(0, ok);
    checks++; if (oq[0].size() != 12) begin errors++; $display("FAIL t6_len got=%0d exp=12", oq[0].size()); end
    for (int i = 0; i < 12 && i < oq[0].size(); i++) begin
      checks++; if (oq[0][i] !== vec[i]) begin errors++; $display("FAIL t6_bit%0d got=%b exp=%b", i, oq[0][i], vec[i]); end
    end
  endtask

  task automatic test_random_frames;
    bit din[$]; bit exp[$];
    int ncyc; bit gov; bit ok; int bad; int len; int rate; int gat; int glen;
    for (int f = 0; f < 12; f++) begin
      int s;
      s = f % 3;
      len = $urandom_range(1, 16);
      rate = $urandom_range(0, 3);
      gat = $urandom_range(0, len - 1);
      glen = $urandom_range(0, 4);
      din.delete();
      for (int i = 0; i < len; i++) din.push_back(bit'($urandom_range(0, 1)));
      model(s, din, rate, exp);
      clear_mon(s);
      start_frame(s, len, rate);
      feed(s, din, gat, glen, ncyc, gov);
      wait_done(s, ok);
      checks++; if (oq[s].size() != exp.size()) begin
        errors++; $display("FAIL rnd%0d_len inst=%0d rate=%0d got=%0d exp=%0d", f, s, rate, oq[s].size(), exp.size());
      end
      bad = 0;
      for (int i = 0; i < exp.size() && i < oq[s].size(); i++) if (oq[s][i] !== exp[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_bits inst=%0d rate=%0d got_mismatches=%0d exp=0", f, s, rate, bad); end
      checks++; if (nlast[s] != 1 || lastpos[s] != exp.size() - 1) begin
        errors++; $display("FAIL rnd%0d_last inst=%0d got_pos=%0d n=%0d exp_pos=%0d n=1", f, s, lastpos[s], nlast[s], exp.size() - 1);
      end
      checks++; if (busy_v[s] !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy inst=%0d got=%b exp=0", f, s, busy_v[s]); end
    end
  endtask

  initial begin
    reset = 1'b0;
    fs_v = '0;
    d_v = '0;
    v_v = '0;
    for (int s = 0; s < 3; s++) begin
      len_a[s] = '0;
      rate_a[s] = '0;
      clear_mon(s);
    end
    test_reset;
    test_t1_rate12;
    test_t2_rate34;
    test_t3_sustained;
    test_t4_gap;
    test_t5_ignored_starts;
    test_t6_reset_midframe;
    test_random_frames;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
